// File: rtl/jt12_i2s_pkg.sv
// -----------------------------------------------------------------------------
// jt12_i2s_pkg
// Shared constants and helpers for the JT12 I2S transmitter.
//   SAMPLE_W        : width of the accumulator's signed sample words (14)
//   slot_pad(sw)    : zero bits appended below the sample inside one slot
//   frame_w(sw)     : bits per stereo frame (two slots)
// -----------------------------------------------------------------------------
package jt12_i2s_pkg;

  localparam int SAMPLE_W = 14;

  function automatic int slot_pad(input int slot_w);
    return slot_w - SAMPLE_W;
  endfunction

  function automatic int frame_w(input int slot_w);
    return 2 * slot_w;
  endfunction

endpackage

// File: rtl/jt12_i2s_clkgen.sv
// -----------------------------------------------------------------------------
// jt12_i2s_clkgen
// Bit-clock generator. A counter runs 0..DIV-1; bclk toggles on each wrap,
// so bclk has a period of 2*DIV clk cycles and starts low after reset.
// Ports:
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   bclk : serial bit clock
//   fall : 1-cycle strobe on the clk edge where bclk goes high -> low
// -----------------------------------------------------------------------------
module jt12_i2s_clkgen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic bclk,
  output logic fall
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] div_cnt;
  logic          wrap;

  assign wrap = (div_cnt == CW'(DIV - 1));
  // bclk is about to drop on this edge
  assign fall = wrap & bclk;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/jt12_i2s_tx.sv
// -----------------------------------------------------------------------------
// jt12_i2s_tx
// I2S transmitter for the JT12 channel accumulator output. Each stereo frame
// is two SLOT_W-bit slots {left, right}; every slot holds the 14-bit sample
// MSB-aligned and zero-padded. A one-entry holding register decouples the
// sample strobe from frame timing; a missing sample repeats the last frame
// (underrun), a sample arriving while holding is full replaces it (overrun).
//
// Build option: define JT12_I2S_LJ_EN for left-justified word select
// (lrck aligned with slot MSB); default is standard I2S (lrck one bit early).
//
// Ports:
//   clk, rst    : system clock, synchronous active-high reset
//   left, right : signed 14-bit samples, valid when sample_en is high
//   sample_en   : single-cycle sample strobe
//   bclk        : bit clock (period 2*DIV clk)
//   lrck        : word select, 0 = left, 1 = right
//   sdata       : serial data, MSB first, changes on bclk falling edge
//   underrun    : 1-cycle pulse, frame loaded without a new sample
//   overrun     : 1-cycle pulse, sample overwrote a full holding register
// -----------------------------------------------------------------------------
module jt12_i2s_tx
  import jt12_i2s_pkg::*;
#(
  parameter int DIV    = 4,
  parameter int SLOT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [SAMPLE_W-1:0] left,
  input  logic signed [SAMPLE_W-1:0] right,
  input  logic                       sample_en,
  output logic                       bclk,
  output logic                       lrck,
  output logic                       sdata,
  output logic                       underrun,
  output logic                       overrun
);

  localparam int FW  = frame_w(SLOT_W);
  localparam int BW  = $clog2(FW);
  localparam int PAD = slot_pad(SLOT_W);

  function automatic logic [SLOT_W-1:0] slot_word(input logic signed [SAMPLE_W-1:0] s);
    return SLOT_W'($unsigned(s)) << PAD;
  endfunction

  logic                       fall;
  logic [BW-1:0]              bit_cnt, bit_nxt, sdata_idx;
  logic [FW-1:0]              frame, frame_nxt;
  logic signed [SAMPLE_W-1:0] hold_l, hold_r, last_l, last_r, src_l, src_r;
  logic                       hold_full, load, under_nxt, lrck_nxt, sdata_nxt;

  jt12_i2s_clkgen #(.DIV(DIV)) u_clkgen (
    .clk  (clk),
    .rst  (rst),
    .bclk (bclk),
    .fall (fall)
  );

  always_comb begin
    bit_nxt   = (bit_cnt == BW'(FW - 1)) ? '0 : bit_cnt + BW'(1);
    load      = fall && (bit_cnt == BW'(FW - 1));

    // Load source priority: holding register, then same-cycle bypass,
    // then repeat of the last transmitted sample.
    src_l     = last_l;
    src_r     = last_r;
    under_nxt = 1'b0;
    if (hold_full) begin
      src_l = hold_l;
      src_r = hold_r;
    end else if (sample_en) begin
      src_l = left;
      src_r = right;
    end else begin
      under_nxt = 1'b1;
    end
    frame_nxt = {slot_word(src_l), slot_word(src_r)};

    // On a load edge the first bit comes from the frame being loaded.
    sdata_idx = BW'(FW - 1) - bit_nxt;
    sdata_nxt = load ? frame_nxt[sdata_idx] : frame[sdata_idx];

`ifdef JT12_I2S_LJ_EN
    lrck_nxt  = (bit_nxt >= BW'(SLOT_W));
`else
    lrck_nxt  = (bit_nxt >= BW'(SLOT_W - 1)) && (bit_nxt <= BW'(FW - 2));
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= BW'(FW - 1);
      frame     <= '0;
      hold_l    <= '0;
      hold_r    <= '0;
      hold_full <= 1'b0;
      last_l    <= '0;
      last_r    <= '0;
      lrck      <= 1'b0;
      sdata     <= 1'b0;
      underrun  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      underrun <= 1'b0;
      overrun  <= 1'b0;

      if (fall) begin
        bit_cnt <= bit_nxt;
        sdata   <= sdata_nxt;
        lrck    <= lrck_nxt;
      end

      if (load) begin
        frame    <= frame_nxt;
        last_l   <= src_l;
        last_r   <= src_r;
        underrun <= under_nxt;
        // A full holding register is consumed; a simultaneous strobe refills it.
        if (hold_full) begin
          hold_full <= sample_en;
          if (sample_en) begin
            hold_l <= left;
            hold_r <= right;
          end
        end
      end else if (sample_en) begin
        hold_l    <= left;
        hold_r    <= right;
        hold_full <= 1'b1;
        overrun   <= hold_full;
      end
    end
  end

endmodule

// File: doc/jt12_i2s_tx.md
Name: jt12_i2s_tx

Overview:
Serial audio transmitter that consumes the per-sample signed 14-bit left/right words produced by the JT12 channel accumulator. It sends them as a standard I2S stream (bclk, lrck, sdata) to an external DAC. A one-entry holding register decouples the accumulator's sample strobe from the serial frame timing. Underrun and overrun are handled deterministically and flagged.

Parameters:
DIV, 4, clk cycles per bclk half-period (bclk period = 2*DIV clk); legal values ≥1
SLOT_W, 16, bclk periods per channel slot; legal values ≥14; frame = 2*SLOT_W bits

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
left  in  14  signed left sample
right  in  14  signed right sample
sample_en  in  1  single-cycle strobe; left/right valid this cycle
bclk  out  1  serial bit clock
lrck  out  1  word select, 0=left, 1=right
sdata  out  1  serial data, MSB first, changes only on bclk falling edge
underrun  out  1  1-cycle pulse: frame loaded with no new sample
overrun  out  1  1-cycle pulse: sample_en while holding register already full

Behaviour:
- Reset: bclk=0, lrck=0, sdata=0, underrun=0, overrun=0; div_cnt=0; bit_cnt=2*SLOT_W-1; frame register=0; holding register empty; last-sample register=0.
- Divider: div_cnt counts 0..DIV-1 and wraps. At wrap, bclk toggles. A fall event occurs on the clk edge where div_cnt==DIV-1 and bclk==1. First rising edge of bclk: DIV clk after reset release. First fall event: 2*DIV clk after reset release.
- Slot word: {sample[13:0], (SLOT_W-14) zeros}, i.e. MSB-aligned and zero-padded.
- Frame register: 2*SLOT_W bits = {left_slot, right_slot}.
- On each fall event, bit_cnt increments modulo 2*SLOT_W.
  - On wrap to 0, the frame register loads.
  - sdata = frame[2*SLOT_W-1-bit_cnt]; this is registered and updated in the same edge as bit_cnt.
- lrck (I2S default): 1 when bit_cnt is in [SLOT_W-1, 2*SLOT_W-2], else 0. lrck therefore leads the slot MSB by one bclk. It updates on the fall event.
- Frame load source, evaluated at the wrap fall event:
  - Holding register full: load it, mark it empty, copy it into last-sample.
  - Holding register empty and sample_en this same cycle: load the incoming sample directly (bypass); holding stays empty; no underrun.
  - Holding register empty and no sample_en: reload last-sample (repeat); underrun=1 for that cycle.
- Holding register write:
  - sample_en on a non-load cycle: write the sample and mark full. If already full, overwrite with the newest sample and set overrun=1 for that cycle.
  - sample_en on a load cycle while holding is full: holding is consumed and the new sample is written; holding stays full; no overrun.
- underrun and overrun are never asserted for more than 1 clk per event.
- First frame after reset: no sample has arrived, so it loads last-sample=0 with underrun=1, unless sample_en coincides with that load.
- Reset mid-frame returns all state to reset values on the next edge; no partial frame completes.

Optional Feature:
JT12_I2S_LJ_EN
- Defined: left-justified format. lrck=1 when bit_cnt is in [SLOT_W, 2*SLOT_W-1]; lrck transitions with the slot MSB (no one-bit lead).
- Undefined: standard I2S timing as in Behaviour.
- Data and load timing are identical in both modes.

Decomposition:
- Package jt12_i2s_pkg:
  - sample width constant (14)
  - slot padding width function (SLOT_W-14)
  - frame width constant expression
- Sub-module jt12_i2s_clkgen: DIV counter; outputs bclk and a 1-cycle fall strobe. The transmitter consumes the fall strobe only.

Test Plan:
- Reset, no samples, DIV=2, SLOT_W=16:
  - first fall event at clk 4 after reset release
  - underrun pulse at that edge
  - sdata=0 for all 32 bits
  - lrck high during bit_cnt 15..30
- left=14'h1234, right=14'h3FFF, strobed before frame start:
  - left slot sdata = 16'h48D0, MSB first
  - right slot sdata = 16'hFFFC
  - no underrun, no overrun
- Two sample_en strobes within one frame (0x0001 then 0x0002 on left):
  - overrun pulse on the second strobe
  - next frame left slot = 16'h0008
- sample_en on the exact wrap fall-event cycle, holding empty, left=14'h2000:
  - bypass load, left slot = 16'h8000
  - no underrun; holding remains empty
- Sample once (left=14'h0155), then no strobes for 3 frames:
  - each frame repeats 16'h0554 with one underrun pulse per frame
- Build with JT12_I2S_LJ_EN, left=14'h1234:
  - lrck falls on the same fall event as left MSB output (bit_cnt 0)
  - rises at bit_cnt 16
  - data identical to the I2S case
